packet_dest_router: RTL and testbench
=====================================

PACKET_DEST_ROUTER -- requirements
Module: packet_dest_router

Interface
REQ-001 SHALL have parameter WIDTH_TYPE, default 2, width of the dest_addr and pack_type fields.
REQ-002 SHALL have parameter WIDTH_PAYLOAD, default 8, width of the payload field.
REQ-003 SHALL have parameter WIDTH_PACKET, default 13, width of a packet: 2*WIDTH_TYPE+WIDTH_PAYLOAD+1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, entries per destination FIFO; a power of 2, at least 2.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port in_packet  input  WIDTH_PACKET  packet from the upstream packet builder: [12:11] dest_addr, [10:9] pack_type, [8:1] payload, [0] eop.
REQ-008 Port in_valid  input  1  in_packet is valid.
REQ-009 Port in_ready  output  1  router accepts in_packet this cycle.
REQ-010 Port out_packet  output  4*WIDTH_PACKET  head packet of FIFO i on slice [i*WIDTH_PACKET +: WIDTH_PACKET].
REQ-011 Port out_valid  output  4  bit i: FIFO i non-empty.
REQ-012 Port out_ready  input  4  bit i: destination i consumes its head packet.

Function
REQ-013 SHALL instantiate 4 independent FIFOs, index = in_packet dest_addr field.
- Each FIFO is FIFO_DEPTH deep.
- Pointers are log2(FIFO_DEPTH)+1 bits.
- full = addresses equal and MSBs differ; empty = pointers equal.
REQ-014 in_ready SHALL be combinational: ~full of FIFO[dest_addr of in_packet]; forced 0 while rst is low.
REQ-015 Push SHALL occur on a rising edge where in_valid & in_ready; the whole 13-bit packet is stored unmodified.
REQ-016 in_valid with in_ready low SHALL leave all state unchanged; the upstream block holds the packet.
REQ-017 out_valid[i] SHALL equal ~empty[i]; out_packet slice i SHALL show the FIFO head combinationally (first-word fall-through).
- Slice value is don't-care when empty; the implementation drives 0.
REQ-018 Pop of FIFO i SHALL occur on a rising edge where out_valid[i] & out_ready[i].
REQ-019 Latency: a packet accepted at edge N SHALL appear with out_valid high in the cycle after edge N; there is no same-cycle bypass.
REQ-020 Simultaneous push and pop on the same non-full, non-empty FIFO SHALL both complete; occupancy is unchanged.
REQ-021 A full FIFO SHALL deassert in_ready even if it pops in the same cycle; the push is taken the following cycle.
REQ-022 out_ready on an empty FIFO SHALL be ignored.
REQ-023 Pointer wrap-around at FIFO_DEPTH SHALL be seamless; order within a FIFO is strictly preserved.
REQ-024 A full FIFO SHALL NOT stall traffic whose dest_addr targets another FIFO.

Reset
REQ-025 While rst is low: all pointers = 0, out_valid = 4'b0000, out_packet = 0, in_ready = 0; FIFO storage need not be cleared.
REQ-026 Reset asserted mid-operation SHALL discard all buffered packets immediately (asynchronously).
REQ-027 First push is possible on the first rising edge after rst rises.

Configuration
REQ-028 Macro ROUTER_EOP_COUNT_EN: when defined, add port eop_count  output  4*8.
- Slice i counts popped packets of FIFO i with eop = 1.
- Counters are 8-bit, saturating at 8'hFF, and reset to 0.
- When the macro is undefined, the port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 Reset: rst low for 55 ns -> in_ready = 0, out_valid = 0000; after rst rises, in_ready = 1.
REQ-030 Single route: in_packet {01,01,AB,1}, in_valid pulse, out_ready = 0000.
- Next cycle: out_valid = 0010; slice 1 = 13'h0B57.
- Pop with out_ready[1] -> out_valid = 0000.
REQ-031 Fill: 4 packets to dest 2 (payload CD..D0) with out_ready = 0.
- in_ready drops after the 4th push; a 5th packet is held.
- Raise out_ready[2] -> packets pop in order CD, CE, CF, D0, then the held 5th.
REQ-032 Isolation: FIFO 2 full, then send {11,11,EF,1} -> accepted at once; out_valid[3] = 1.
REQ-033 Wrap/simultaneous: dest 0 streams 12 packets with out_ready[0] = 1 every cycle -> all 12 delivered in order; no loss.
REQ-034 Reset mid-stream and EOP counter: with FIFOs 1 and 3 holding 2 packets each, pull rst low.
- Immediately: out_valid = 0000.
- With ROUTER_EOP_COUNT_EN defined: eop_count = 0.

Source files
------------

// File: rtl/packet_dest_router.sv
// Four-way packet router: each packet is queued in the first-word fall-through FIFO chosen by its dest_addr field.
// Optional per-destination popped-EOP counters are enabled by defining ROUTER_EOP_COUNT_EN.
module packet_dest_router #(
    parameter int WIDTH_TYPE    = 2,
    parameter int WIDTH_PAYLOAD = 8,
    parameter int WIDTH_PACKET  = 2*WIDTH_TYPE + WIDTH_PAYLOAD + 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH_PACKET-1:0]   in_packet,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [4*WIDTH_PACKET-1:0] out_packet,
    output logic [3:0]                out_valid,
    input  logic [3:0]                out_ready
`ifdef ROUTER_EOP_COUNT_EN
    ,
    output logic [4*8-1:0]            eop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]           wr_ptr_q [4];
    logic [PW-1:0]           wr_ptr_d [4];
    logic [PW-1:0]           rd_ptr_q [4];
    logic [PW-1:0]           rd_ptr_d [4];
    logic [WIDTH_PACKET-1:0] mem_q    [4][FIFO_DEPTH];

    logic [WIDTH_TYPE-1:0]   dest_field;
    logic [1:0]              dest;
    logic [3:0]              full;
    logic [3:0]              empty;
    logic [3:0]              push;
    logic [3:0]              pop;

    assign dest_field = in_packet[WIDTH_PACKET-1 -: WIDTH_TYPE];
    assign dest       = dest_field[1:0];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        full       = '0;
        empty      = '0;
        push       = '0;
        pop        = '0;
        out_valid  = '0;
        out_packet = '0;
        for (int i = 0; i < 4; i++) begin
            full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                       (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
        end
        // A full FIFO refuses the push even when it pops this cycle.
        in_ready = rst & ~full[dest];
        for (int i = 0; i < 4; i++) begin
            push[i]      = in_valid & in_ready & (dest == 2'(i));
            pop[i]       = out_ready[i] & ~empty[i];
            wr_ptr_d[i]  = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i]  = rd_ptr_q[i] + PW'(pop[i]);
            out_valid[i] = ~empty[i];
            if (!empty[i]) begin
                out_packet[i*WIDTH_PACKET +: WIDTH_PACKET] = mem_q[i][rd_ptr_q[i][AW-1:0]];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    // NOTE: packet storage is deliberately not reset; clearing the pointers already empties every FIFO.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_packet;
            end
        end
    end

`ifdef ROUTER_EOP_COUNT_EN
    logic [7:0] eop_cnt_q [4];
    logic [7:0] eop_cnt_d [4];

    // Counts popped end-of-packet beats per destination, saturating at 8'hFF.
    always_comb begin
        eop_count = '0;
        for (int i = 0; i < 4; i++) begin
            eop_cnt_d[i] = eop_cnt_q[i];
            if (pop[i] && out_packet[i*WIDTH_PACKET] && (eop_cnt_q[i] != 8'hFF)) begin
                eop_cnt_d[i] = eop_cnt_q[i] + 8'd1;
            end
            eop_count[i*8 +: 8] = eop_cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                eop_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                eop_cnt_q[i] <= eop_cnt_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_packet_dest_router.sv
// Directed, table-driven bench for packet_dest_router (default parameters).
// Define ROUTER_EOP_COUNT_EN for both files to exercise the EOP counters.
module tb_packet_dest_router;

    localparam int W = 13;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_packet;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] out_packet;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
`ifdef ROUTER_EOP_COUNT_EN
    logic [31:0]    eop_count;
`endif

    packet_dest_router dut (
        .clk        (clk),
        .rst        (rst),
        .in_packet  (in_packet),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_packet (out_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef ROUTER_EOP_COUNT_EN
        ,
        .eop_count  (eop_count)
`endif
    );

    // Rising edges at 10, 20, ...; inputs change and outputs are sampled around falling edges.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [W-1:0] pk;
        logic [3:0]   ordy;
        logic         exp_ir;
        logic [3:0]   exp_ov;
        int           idx;
        logic [W-1:0] exp_head;
    } vec_t;

    vec_t vecs[32];
    int   n_vec;
    int   n_cmp;
    int   n_fail;

    function automatic logic [W-1:0] pkt(input logic [1:0] d, input logic [1:0] t,
                                         input logic [7:0] p, input logic e);
        return {d, t, p, e};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [W-1:0] pk, input logic [3:0] ordy,
                       input logic exp_ir, input logic [3:0] exp_ov, input int idx,
                       input logic [W-1:0] head);
        vecs[n_vec] = '{iv, pk, ordy, exp_ir, exp_ov, idx, head};
        n_vec++;
    endtask

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_pk;
    logic [W-1:0] a_pk;
    logic [W-1:0] f_pk;
    logic [W-1:0] r_pk;
    int           sent;
    int           delivered;

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        n_vec     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_packet = pkt(2'd1, 2'd1, 8'hAB, 1'b1);
        out_ready = 4'b0000;

        a_pk = pkt(2'd1, 2'd1, 8'hAB, 1'b1);
        f_pk = pkt(2'd3, 2'd3, 8'hEF, 1'b1);

        // Single route to dest 1.
        add(0, a_pk, 4'b0000, 1, 4'b0000, -1, '0);
        add(1, a_pk, 4'b0000, 1, 4'b0000, -1, '0);
        add(0, a_pk, 4'b0000, 1, 4'b0010,  1, 13'h0B57);
        add(0, a_pk, 4'b0010, 1, 4'b0010,  1, 13'h0B57);
        add(0, a_pk, 4'b0000, 1, 4'b0000,  1, '0);
        // Fill dest 2 with CD..D0, hold D1, drain in order.
        add(1, pkt(2, 2, 8'hCD, 0), 4'b0000, 1, 4'b0000, -1, '0);
        add(1, pkt(2, 2, 8'hCE, 0), 4'b0000, 1, 4'b0100,  2, pkt(2, 2, 8'hCD, 0));
        add(1, pkt(2, 2, 8'hCF, 0), 4'b0000, 1, 4'b0100,  2, pkt(2, 2, 8'hCD, 0));
        add(1, pkt(2, 2, 8'hD0, 0), 4'b0000, 1, 4'b0100,  2, pkt(2, 2, 8'hCD, 0));
        add(1, pkt(2, 2, 8'hD1, 0), 4'b0000, 0, 4'b0100,  2, pkt(2, 2, 8'hCD, 0));
        add(1, pkt(2, 2, 8'hD1, 0), 4'b0100, 0, 4'b0100,  2, pkt(2, 2, 8'hCD, 0));
        add(1, pkt(2, 2, 8'hD1, 0), 4'b0100, 1, 4'b0100,  2, pkt(2, 2, 8'hCE, 0));
        add(0, pkt(2, 2, 8'hD1, 0), 4'b0100, 1, 4'b0100,  2, pkt(2, 2, 8'hCF, 0));
        add(0, pkt(2, 2, 8'hD1, 0), 4'b0100, 1, 4'b0100,  2, pkt(2, 2, 8'hD0, 0));
        add(0, pkt(2, 2, 8'hD1, 0), 4'b0100, 1, 4'b0100,  2, pkt(2, 2, 8'hD1, 0));
        add(0, pkt(2, 2, 8'hD1, 0), 4'b0100, 1, 4'b0000,  2, '0);
        add(0, pkt(2, 2, 8'hD1, 0), 4'b0000, 1, 4'b0000,  2, '0);
        // Isolation: dest 2 full, dest 3 still accepted.
        add(1, pkt(2, 2, 8'hE0, 0), 4'b0000, 1, 4'b0000, -1, '0);
        add(1, pkt(2, 2, 8'hE1, 0), 4'b0000, 1, 4'b0100,  2, pkt(2, 2, 8'hE0, 0));
        add(1, pkt(2, 2, 8'hE2, 0), 4'b0000, 1, 4'b0100,  2, pkt(2, 2, 8'hE0, 0));
        add(1, pkt(2, 2, 8'hE3, 0), 4'b0000, 1, 4'b0100,  2, pkt(2, 2, 8'hE0, 0));
        add(0, pkt(2, 2, 8'hE4, 0), 4'b0000, 0, 4'b0100,  2, pkt(2, 2, 8'hE0, 0));
        add(1, f_pk,                4'b0000, 1, 4'b0100,  3, '0);
        add(0, f_pk,                4'b0000, 1, 4'b1100,  3, f_pk);
        add(0, f_pk,                4'b1100, 1, 4'b1100,  2, pkt(2, 2, 8'hE0, 0));
        add(0, f_pk,                4'b1100, 1, 4'b0100,  2, pkt(2, 2, 8'hE1, 0));
        add(0, f_pk,                4'b1100, 1, 4'b0100,  2, pkt(2, 2, 8'hE2, 0));
        add(0, f_pk,                4'b1100, 1, 4'b0100,  2, pkt(2, 2, 8'hE3, 0));
        add(0, f_pk,                4'b0000, 1, 4'b0000, -1, '0);

        // Reset held low for 55 ns.
        repeat (5) @(negedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_packet", 64'(out_packet), 64'd0);
        #9 rst = 1'b1;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < n_vec; i++) begin
            in_valid  = vecs[i].iv;
            in_packet = vecs[i].pk;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (vecs[i].idx >= 0) begin
                check($sformatf("v%0d slice%0d", i, vecs[i].idx),
                      64'(out_packet[vecs[i].idx*W +: W]), 64'(vecs[i].exp_head));
            end
            @(negedge clk);
        end

        // Dest 0 streams 12 packets with out_ready[0] held high; pointers wrap three times.
        sent      = 0;
        delivered = 0;
        out_ready = 4'b0001;
        for (int c = 0; c < 40 && delivered < 12; c++) begin
            in_valid  = (sent < 12);
            in_packet = pkt(2'd0, 2'd1, 8'(8'h10 + sent), sent[0]);
            #1;
            if (out_valid[0]) begin
                if (exp_q.size() == 0) begin
                    check("stream spurious out_valid", 64'(out_valid[0]), 64'd0);
                end else begin
                    exp_pk = exp_q.pop_front();
                    check($sformatf("stream pkt%0d", delivered), 64'(out_packet[0 +: W]), 64'(exp_pk));
                    delivered++;
                end
            end
            if (in_valid) begin
                check($sformatf("stream in_ready%0d", sent), 64'(in_ready), 64'd1);
                if (in_ready) begin
                    exp_q.push_back(in_packet);
                    sent++;
                end
            end
            @(negedge clk);
        end
        check("stream delivered count", 64'(delivered), 64'd12);
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // Load two packets each into dest 1 and dest 3, then reset mid-stream.
        in_valid  = 1'b1;
        in_packet = pkt(2'd1, 2'd0, 8'h11, 1'b1);
        @(negedge clk);
        in_packet = pkt(2'd1, 2'd0, 8'h12, 1'b0);
        @(negedge clk);
        in_packet = pkt(2'd3, 2'd0, 8'h31, 1'b1);
        @(negedge clk);
        in_packet = pkt(2'd3, 2'd0, 8'h32, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("loaded out_valid", 64'(out_valid), 64'b1010);
        check("loaded slice3", 64'(out_packet[3*W +: W]), 64'(pkt(2'd3, 2'd0, 8'h31, 1'b1)));
`ifdef ROUTER_EOP_COUNT_EN
        check("eop_count slice0", 64'(eop_count[7:0]), 64'd6);
        check("eop_count slice1", 64'(eop_count[15:8]), 64'd1);
        check("eop_count slice2", 64'(eop_count[23:16]), 64'd0);
        check("eop_count slice3", 64'(eop_count[31:24]), 64'd1);
`endif
        #1 rst = 1'b0;
        #1;
        check("mid-reset out_valid", 64'(out_valid), 64'd0);
        check("mid-reset in_ready", 64'(in_ready), 64'd0);
        check("mid-reset out_packet", 64'(out_packet), 64'd0);
`ifdef ROUTER_EOP_COUNT_EN
        check("mid-reset eop_count", 64'(eop_count), 64'd0);
`endif

        // First push is taken on the first rising edge after release.
        @(negedge clk);
        rst       = 1'b1;
        r_pk      = pkt(2'd1, 2'd2, 8'h5A, 1'b1);
        in_valid  = 1'b1;
        in_packet = r_pk;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        check("release out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("first push out_valid", 64'(out_valid), 64'b0010);
        check("first push slice1", 64'(out_packet[1*W +: W]), 64'(r_pk));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
